// File: rtl/register_file_pkg.sv
// Shared sizing constants for the register file and its lanes.
package register_file_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_ROWS   = 8;
  localparam int RF_DEPTH  = 32;
  localparam int RF_IDX_W  = $clog2(RF_DEPTH);
  localparam int RF_LANES  = 2 * RF_ROWS;
  localparam int RF_SEL_W  = $clog2(RF_LANES);
endpackage

// File: rtl/register_file_rf_lane.sv
// One storage lane: DEPTH x DATA_W entries, one write port, one registered indexed read.
module rf_lane
  import register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int IDX_W  = RF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Read and write share the edge: a read sees the value before a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/register_file.sv
// Sixteen-lane register file: buffered loads, pointer-driven X/W streaming.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ROWS   = RF_ROWS,
  parameter int DEPTH  = RF_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RF_EN,
  input  logic                        WRITE,
  input  logic [$clog2(2*ROWS)-1:0]   REG_SELECT,
  input  logic [$clog2(DEPTH)-1:0]    IDX,
  input  logic [DATA_W-1:0]           DIN,
  output logic [DATA_W-1:0]           X_OUT [0:ROWS-1],
  output logic [DATA_W-1:0]           W_OUT [0:ROWS-1]
);

  localparam int LANES = 2 * ROWS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SEL_W = $clog2(LANES);

  // Control: RF_EN gates capture/stream/pointer; a captured write always
  // commits on the following edge regardless of RF_EN or WRITE.
  logic              load_edge;
  logic              stream_edge;
  logic              wb_pending;
  logic [SEL_W-1:0]  wb_sel;
  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] lane_q [0:LANES-1];

  assign load_edge   = RF_EN &  WRITE;
  assign stream_edge = RF_EN & ~WRITE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_pending <= 1'b0;
      wb_sel     <= '0;
      wb_idx     <= '0;
      wb_data    <= '0;
      ptr        <= '0;
    end else begin
      wb_pending <= load_edge;
      if (load_edge) begin
        wb_sel  <= REG_SELECT;
        wb_idx  <= IDX;
        wb_data <= DIN;
        ptr     <= '0;
      end else if (stream_edge) begin
        ptr <= (ptr == IDX_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rf_lane #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .we   (wb_pending && (wb_sel == SEL_W'(i))),
      .waddr(wb_idx),
      .wdata(wb_data),
      .re   (stream_edge),
      .raddr(ptr),
      .rdata(lane_q[i])
    );
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_out
    assign X_OUT[r] = lane_q[r];
    assign W_OUT[r] = lane_q[ROWS + r];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: load/stream, skew, write buffer, wrap, enable, reset.
module tb_register_file;

  logic        CLK;
  logic        RST;
  logic        RF_EN;
  logic        WRITE;
  logic [3:0]  REG_SELECT;
  logic [4:0]  IDX;
  logic [15:0] DIN;
  logic [15:0] X_OUT [0:7];
  logic [15:0] W_OUT [0:7];

  int n_vec  = 0;
  int n_miss = 0;
  bit abcd_loaded = 0;

  register_file dut (
    .CLK       (CLK),
    .RST       (RST),
    .RF_EN     (RF_EN),
    .WRITE     (WRITE),
    .REG_SELECT(REG_SELECT),
    .IDX       (IDX),
    .DIN       (DIN),
    .X_OUT     (X_OUT),
    .W_OUT     (W_OUT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic en, input logic wr, input logic [3:0] sel,
                      input logic [4:0] idx, input logic [15:0] din);
    RF_EN = en; WRITE = wr; REG_SELECT = sel; IDX = idx; DIN = din;
    @(posedge CLK);
    #1;
  endtask

  task automatic stream_step();
    step(1'b1, 1'b0, 4'd0, 5'd0, 16'h0);
  endtask

  // Contents after the skewed load: lane i (row r = i % 8) holds n-r at entry n.
  function automatic logic [15:0] skew_val(input int lane, input int n);
    int r;
    r = lane % 8;
    if (abcd_loaded && lane == 5 && n == 0) return 16'hABCD;
    if (n - r >= 1 && n - r <= 8) return 16'(n - r);
    return 16'h0;
  endfunction

  function automatic logic [15:0] or_all();
    logic [15:0] acc;
    acc = '0;
    for (int r = 0; r < 8; r++) acc = acc | X_OUT[r] | W_OUT[r];
    return acc;
  endfunction

  initial begin
    RST = 1'b1; RF_EN = 0; WRITE = 0; REG_SELECT = 0; IDX = 0; DIN = 0;
    #12;
    for (int r = 0; r < 8; r++) begin
      check("reset_x", X_OUT[r], 16'h0);
      check("reset_w", W_OUT[r], 16'h0);
    end
    check("reset_ptr", 16'(dut.ptr), 16'h0);
    RST = 1'b0;

    // lane 0 loaded at entries 1..8, one extra edge, then stream
    for (int j = 1; j <= 8; j++) step(1'b1, 1'b1, 4'd0, 5'(j), 16'(j));
    step(1'b0, 1'b0, 4'd0, 5'd0, 16'h0);
    for (int k = 0; k < 10; k++) begin
      stream_step();
      check("load_x0", X_OUT[0], (k >= 1 && k <= 8) ? 16'(k) : 16'h0);
    end

    // full skewed load of all 16 lanes
    for (int j = 1; j <= 8; j++)
      for (int i = 0; i < 16; i++)
        step(1'b1, 1'b1, 4'(i), (i < 8) ? 5'(j + i) : 5'(j + i - 8), 16'(j));
    step(1'b0, 1'b0, 4'd0, 5'd0, 16'h0);
    for (int k = 0; k < 16; k++) begin
      stream_step();
      check("skew_x3", X_OUT[3], (k >= 4 && k <= 11) ? 16'(k - 3) : 16'h0);
      check("skew_w7", W_OUT[7], (k >= 8 && k <= 15) ? 16'(k - 7) : 16'h0);
      check("skew_x0", X_OUT[0], (k >= 1 && k <= 8) ? 16'(k) : 16'h0);
      check("skew_w0", W_OUT[0], (k >= 1 && k <= 8) ? 16'(k) : 16'h0);
    end

    // write buffer: stream edge coinciding with commit sees the old value
    step(1'b1, 1'b1, 4'd5, 5'd0, 16'hABCD);
    stream_step();
    check("wbuf_old", X_OUT[5], 16'h0);
    abcd_loaded = 1;
    step(1'b1, 1'b1, 4'd5, 5'd0, 16'hABCD);
    stream_step();
    check("wbuf_new", X_OUT[5], 16'hABCD);

    // wrap: 33 stream edges
    step(1'b1, 1'b1, 4'd5, 5'd0, 16'hABCD);
    for (int k = 0; k <= 32; k++) begin
      stream_step();
      check("wrap_x5", X_OUT[5], skew_val(5, k % 32));
      check("wrap_w7", W_OUT[7], skew_val(15, k % 32));
      check("wrap_ptr", 16'(dut.ptr), 16'((k + 1) % 32));
    end

    // enable low mid-stream; WRITE high while disabled must not capture
    step(1'b1, 1'b1, 4'd5, 5'd0, 16'hABCD);
    for (int k = 0; k < 5; k++) begin
      stream_step();
      check("en_pre_x3", X_OUT[3], skew_val(3, k));
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 4'd3, 5'd6, 16'h7777);
      check("en_hold_x3", X_OUT[3], skew_val(3, 4));
      check("en_hold_ptr", 16'(dut.ptr), 16'd5);
    end
    for (int k = 5; k < 10; k++) begin
      stream_step();
      check("en_resume_x3", X_OUT[3], skew_val(3, k));
      check("en_resume_w7", W_OUT[7], skew_val(15, k));
    end

    // asynchronous reset mid-stream, between edges
    #2 RST = 1'b1;
    #1;
    check("rst_async_x3", X_OUT[3], 16'h0);
    check("rst_async_all", or_all(), 16'h0);
    check("rst_async_ptr", 16'(dut.ptr), 16'h0);
    RST = 1'b0;

    // pending write discarded by reset; stream starts at entry 0 and reads zeros
    step(1'b1, 1'b1, 4'd0, 5'd2, 16'h5555);
    #2 RST = 1'b1;
    #1 RST = 1'b0;
    for (int k = 0; k < 32; k++) begin
      stream_step();
      check("rst_zero_all", or_all(), 16'h0);
      if (k == 0) check("rst_first_ptr", 16'(dut.ptr), 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, element width; ROWS, default 8, lanes per operand bank; DEPTH, default 32, entries per lane (index width log2(DEPTH) = 5).
REQ-002 Port CLK, input, 1, the only clock; all state changes on its rising edge.
REQ-003 Port RST, input, 1, asynchronous active-high reset.
REQ-004 Port RF_EN, input, 1, block enable; when low, no capture, no read and no pointer advance occur.
REQ-005 Port WRITE, input, 1, mode: 1 = load, 0 = stream out.
REQ-006 Port REG_SELECT, input, 4, lane select: 0..7 = X lanes 0..7, 8..15 = W lanes 0..7.
REQ-007 Port IDX, input, 5, entry index within the selected lane.
REQ-008 Port DIN, input, DATA_W, write data.
REQ-009 Port X_OUT, output, unpacked array [0:ROWS-1] of DATA_W, registered X-lane stream.
REQ-010 Port W_OUT, output, unpacked array [0:ROWS-1] of DATA_W, registered W-lane stream.

Function
REQ-011 Storage SHALL be 16 lanes x DEPTH entries x DATA_W bits, with no read or write port other than those defined below.
REQ-012 On an edge with RF_EN=1 and WRITE=1, {REG_SELECT, IDX, DIN} SHALL be captured into a one-entry write buffer and marked pending.
REQ-013 A pending buffer SHALL be committed to lane[REG_SELECT][IDX] on the next rising edge, whatever the values of WRITE and RF_EN; write latency is therefore 2 edges from capture to storage.
REQ-014 Back-to-back writes SHALL sustain one write per cycle: each edge commits the previous capture and captures the new one.
REQ-015 On an edge with RF_EN=1 and WRITE=0 (stream edge), the block SHALL load X_OUT[r] <= lane[r][ptr] and W_OUT[r] <= lane[8+r][ptr] for r = 0..7, then increment ptr.
REQ-016 ptr SHALL be 5 bits and wrap from DEPTH-1 to 0.
REQ-017 ptr SHALL be cleared to 0 on every edge with RF_EN=1 and WRITE=1, so each stream burst starts at entry 0.
REQ-018 When a commit and a stream edge coincide, the stream SHALL read the pre-commit contents; there is no bypass path.
REQ-019 Outputs SHALL hold their last value on edges that are not stream edges.
REQ-020 Writes SHALL NOT clear entries that are not written; stale data persists until overwritten or reset.
REQ-021 Skewed loading by the caller (lane r written at IDX = r+1 .. r+8) SHALL yield a diagonal wavefront on the outputs without any internal skew logic.

Reset
REQ-022 RST high SHALL asynchronously clear all storage entries, ptr, the write buffer and its pending flag, and all X_OUT and W_OUT elements to 0.
REQ-023 If RST is asserted during a load or stream burst, a pending write SHALL be discarded, and after release the first stream edge SHALL read entry 0.

Structure
REQ-024 A shared package SHALL hold DATA_W, ROWS, DEPTH, the index width and the lane-count constant (2*ROWS).
REQ-025 One sub-module, rf_lane, SHALL implement a single DEPTH x DATA_W lane with a write port and an indexed registered read; the top level SHALL instantiate it 16 times, together with the write buffer, the decode logic and ptr.

Verification
REQ-026 Verification SHALL cover load then stream: lane 0 loaded at IDX 1..8 with data 1..8, then one extra edge, then stream -> X_OUT[0] = 0, 1..8, 0 on stream edges 0..9.
REQ-027 Verification SHALL cover the skew: full 16-lane skewed load (lane i<8 at IDX j+i, lane i>=8 at IDX j+i-8, data j = 1..8) -> X_OUT[3] = 1..8 on stream edges 4..11, and W_OUT[7] = 1..8 on stream edges 8..15.
REQ-028 Verification SHALL cover the write buffer: a single write to lane 5, IDX 0, data 0xABCD, followed immediately by WRITE=0 -> stream edge 0 shows the old value 0, and a second burst (WRITE pulse, then stream) shows 0xABCD on edge 0.
REQ-029 Verification SHALL cover wrap: 33 stream edges -> ptr returns to 0, and edge 32 output equals edge 0 output.
REQ-030 Verification SHALL cover enable: RF_EN=0 for 3 edges mid-stream -> outputs and ptr frozen, and the stream resumes at the next entry.
REQ-031 Verification SHALL cover reset: RST pulsed mid-stream, asynchronously and between edges -> all outputs 0 immediately, and a subsequent stream returns all zeros.
